// File: rtl/jtag_scan_engine.sv
// Command-driven JTAG master: walks the TAP through IR/DR scans, resets and idle
// cycles, tracking the TAP state from the TMS it emits and capturing TDO while shifting.
module jtag_scan_engine #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic [3:0]         tap_state
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;

  localparam logic [3:0] TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3;
  localparam logic [3:0] SHDR  = 4'd4,  EX1DR = 4'd5,  PSDR  = 4'd6,  EX2DR = 4'd7;
  localparam logic [3:0] UPDR  = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11;
  localparam logic [3:0] EX1IR = 4'd12, PSIR  = 4'd13, EX2IR = 4'd14, UPIR  = 4'd15;

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_HDR, S_SHIFT, S_TRAIL, S_RST, S_WAIT
  } eng_e;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    n = TLR;
    case (s)
      TLR:     n = tms ? TLR   : RTI;
      RTI:     n = tms ? SELDR : RTI;
      SELDR:   n = tms ? SELIR : CAPDR;
      CAPDR:   n = tms ? EX1DR : SHDR;
      SHDR:    n = tms ? EX1DR : SHDR;
      EX1DR:   n = tms ? UPDR  : PSDR;
      PSDR:    n = tms ? EX2DR : PSDR;
      EX2DR:   n = tms ? UPDR  : SHDR;
      UPDR:    n = tms ? SELDR : RTI;
      SELIR:   n = tms ? TLR   : CAPIR;
      CAPIR:   n = tms ? EX1IR : SHIR;
      SHIR:    n = tms ? EX1IR : SHIR;
      EX1IR:   n = tms ? UPIR  : PSIR;
      PSIR:    n = tms ? EX2IR : PSIR;
      EX2IR:   n = tms ? UPIR  : SHIR;
      UPIR:    n = tms ? SELDR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  eng_e               st_q;
  logic [3:0]         tap_q, tap_d;
  logic               tms_q, tdi_q, busy_q, rsp_valid_q;
  logic [MAX_LEN-1:0] rsp_data_q, cap_q, data_q;
  logic [IDX_W-1:0]   cidx_q;
  logic [LEN_W-1:0]   cnt_q, len_q, len_d;
  logic [1:0]         op_q;

  // The TMS registered on the previous edge is what the TAP consumes on this one.
  assign tap_d = tap_next(tap_q, tms_q);

  always_comb begin
    len_d = cmd_len;
    if (cmd_len == '0)
      len_d = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))
      len_d = LEN_W'(MAX_LEN);
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      st_q        <= S_BOOT;
      tap_q       <= TLR;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cap_q       <= '0;
      cidx_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
    end else begin
      tap_q       <= tap_d;
      rsp_valid_q <= 1'b0;
      if (tap_q == SHDR || tap_q == SHIR) begin
        cap_q[cidx_q] <= TDO;
        cidx_q        <= cidx_q + IDX_W'(1);
      end
      case (st_q)
        S_BOOT: begin
          tms_q  <= 1'b0;
          busy_q <= 1'b0;
          st_q   <= S_IDLE;
        end
        S_IDLE: begin
          tms_q <= 1'b0;
          tdi_q <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            busy_q <= 1'b1;
            op_q   <= cmd_op;
            len_q  <= len_d;
            data_q <= cmd_data;
            cap_q  <= '0;
            cidx_q <= '0;
            case (cmd_op)
              OP_RST: begin
                tms_q <= 1'b1;
                cnt_q <= LEN_W'(5);
                st_q  <= S_RST;
              end
              OP_IR: begin
                tms_q <= 1'b1;
                cnt_q <= LEN_W'(3);
                st_q  <= S_HDR;
              end
              OP_DR: begin
                tms_q <= 1'b1;
                cnt_q <= LEN_W'(2);
                st_q  <= S_HDR;
              end
              default: begin
                tms_q <= 1'b0;
                cnt_q <= len_d - LEN_W'(1);
                st_q  <= (len_d == LEN_W'(1)) ? S_WAIT : S_RST;
              end
            endcase
          end
        end
        S_HDR: begin
          // Remaining header after the leading 1: DR gives 0,0 and IR gives 1,0,0.
          tms_q <= (cnt_q == LEN_W'(3));
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            cnt_q <= len_q;
            st_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          tms_q  <= (cnt_q == LEN_W'(1));
          tdi_q  <= data_q[0];
          data_q <= data_q >> 1;
          cnt_q  <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            cnt_q <= LEN_W'(2);
            st_q  <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          tdi_q <= 1'b0;
          tms_q <= (cnt_q == LEN_W'(2));
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1))
            st_q <= S_WAIT;
        end
        S_RST: begin
          tms_q <= (op_q == OP_RST) && (cnt_q > LEN_W'(1));
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1))
            st_q <= S_WAIT;
        end
        S_WAIT: begin
          tms_q       <= 1'b0;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= cap_q;
          st_q        <= S_IDLE;
        end
        default: begin
          tms_q <= 1'b0;
          st_q  <= S_BOOT;
        end
      endcase
    end
  end

  assign cmd_ready = (st_q == S_IDLE) && !busy_q && (tap_q == RTI);
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign tap_state = tap_q;

endmodule

// File: tb/tb_jtag_scan_engine.sv
// Directed bench for jtag_scan_engine: hand-derived TMS/TDI streams, TAP paths and
// captured words for DR/IR scans, length boundaries, TAP reset/idle chaining and TRST abort.
module tb_jtag_scan_engine;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               TCK = 1'b0;
  logic               TRST;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               TMS, TDI, TDO;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic [3:0]         tap_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  jtag_scan_engine #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .TMS(TMS), .TDI(TDI), .TDO(TDO), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .tap_state(tap_state)
  );

  always #5 TCK = ~TCK;

  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream bit k sits at position nbits-1-k (streams are written first-bit-leftmost);
  // path nibble k is the TAP state seen after edge e0+k.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [LEN_W-1:0] len,
                         input logic [31:0] data, input int nbits, input int win_lo,
                         input int win_n, input logic [31:0] tdo_word,
                         input logic [63:0] exp_tms, input logic [63:0] exp_tdi,
                         input logic chk_path, input logic [255:0] exp_path,
                         input logic [31:0] exp_rsp);
    chk({name, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    TDO       = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = ~len;
    cmd_data  = ~data;
    for (int k = 0; k < nbits; k++) begin
      TDO = (k >= win_lo && k < win_lo + win_n) ? tdo_word[k - win_lo] : 1'b1;
      chk($sformatf("%s.tms[%0d]", name, k), TMS, exp_tms[nbits - 1 - k]);
      chk($sformatf("%s.tdi[%0d]", name, k), TDI, exp_tdi[nbits - 1 - k]);
      chk($sformatf("%s.busy[%0d]", name, k), busy, 1);
      chk($sformatf("%s.rspv[%0d]", name, k), rsp_valid, 0);
      if (chk_path)
        chk($sformatf("%s.tap[%0d]", name, k), tap_state, exp_path[4*k +: 4]);
      step();
    end
    TDO = 1'b1;
    chk({name, ".rsp_valid"}, rsp_valid, 1);
    chk({name, ".rsp_data"}, rsp_data, exp_rsp);
    chk({name, ".busy_end"}, busy, 0);
    chk({name, ".ready_end"}, cmd_ready, 1);
    chk({name, ".tms_end"}, TMS, 0);
    chk({name, ".tap_end"}, tap_state, 1);
    if (chk_path)
      chk({name, ".tap_path_end"}, tap_state, exp_path[4*nbits +: 4]);
  endtask

  initial begin
    TRST      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    cmd_data  = '0;
    TDO       = 1'b1;

    // Boot
    repeat (3) step();
    chk("rst.tap", tap_state, 0);
    chk("rst.busy", busy, 1);
    chk("rst.ready", cmd_ready, 0);
    chk("rst.tms", TMS, 0);
    chk("rst.tdi", TDI, 0);
    chk("rst.rspv", rsp_valid, 0);
    chk("rst.rspd", rsp_data, 0);
    TRST = 1'b0;
    step();
    chk("boot.tap", tap_state, 1);
    chk("boot.ready", cmd_ready, 1);
    chk("boot.tms", TMS, 0);
    chk("boot.rspd", rsp_data, 0);
    chk("boot.busy", busy, 0);
    step();

    // DR scan, N=8, data 0xA5, TAP returns 0x3C
    run_cmd("dr8", 2'b10, 6'd8, 32'h0000_00A5, 13, 3, 8, 32'h0000_003C,
            64'(13'b1000000000110), 64'(13'b0001010010100),
            1'b1, 256'(56'h18544444444321), 32'h0000_003C);
    step();
    chk("dr8.hold_rspv", rsp_valid, 0);
    chk("dr8.hold_rspd", rsp_data, 32'h0000_003C);

    // IR scan, N=5, data 0x11, TAP returns 0x16
    run_cmd("ir5", 2'b01, 6'd5, 32'h0000_0011, 11, 4, 5, 32'h0000_0016,
            64'(11'b11000000110), 64'(11'b00001000100),
            1'b1, 256'(48'h1FCBBBBBA921), 32'h0000_0016);
    step();

    // cmd_len=0 behaves as a single shift bit
    run_cmd("dr0", 2'b10, 6'd0, 32'hFFFF_FFFF, 6, 3, 1, 32'h0000_0000,
            64'(6'b100110), 64'(6'b000100), 1'b0, '0, 32'h0000_0000);
    step();

    // Full length, all ones in and out
    run_cmd("dr32", 2'b10, 6'd32, 32'hFFFF_FFFF, 37, 3, 32, 32'hFFFF_FFFF,
            64'(37'b100_0000000_00000000_00000000_00000000_110),
            64'(37'b000_11111111_11111111_11111111_11111111_00),
            1'b0, '0, 32'hFFFF_FFFF);
    step();

    // Over-length request clamps to MAX_LEN
    run_cmd("dr63", 2'b10, 6'd63, 32'hFFFF_FFFF, 37, 3, 32, 32'h1234_5678,
            64'(37'b100_0000000_00000000_00000000_00000000_110),
            64'(37'b000_11111111_11111111_11111111_11111111_00),
            1'b0, '0, 32'h1234_5678);
    step();

    // TAP reset, then idle 3 and a DR scan each accepted in the rsp_valid cycle
    run_cmd("tapr", 2'b00, 6'd7, 32'hFFFF_FFFF, 6, 0, 0, 32'h0,
            64'(6'b111110), 64'(6'b000000), 1'b1, 256'(28'h1000921), 32'h0);
    run_cmd("idle3", 2'b11, 6'd3, 32'hFFFF_FFFF, 3, 0, 0, 32'h0,
            64'(3'b000), 64'(3'b000), 1'b1, 256'(16'h1111), 32'h0);
    run_cmd("dr8b", 2'b10, 6'd8, 32'h0000_00A5, 13, 3, 8, 32'h0000_003C,
            64'(13'b1000000000110), 64'(13'b0001010010100),
            1'b1, 256'(56'h18544444444321), 32'h0000_003C);
    step();

    // TRST in the middle of a shift
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 6'd8;
    cmd_data  = 32'h0000_00A5;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    chk("abort.tap_pre", tap_state, 4);
    TRST = 1'b1;
    #1;
    chk("abort.tms", TMS, 0);
    chk("abort.tdi", TDI, 0);
    chk("abort.tap", tap_state, 0);
    chk("abort.busy", busy, 1);
    chk("abort.ready", cmd_ready, 0);
    chk("abort.rspv", rsp_valid, 0);
    chk("abort.rspd", rsp_data, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort.hold_rspv[%0d]", k), rsp_valid, 0);
      chk($sformatf("abort.hold_tap[%0d]", k), tap_state, 0);
    end
    TRST = 1'b0;
    step();
    chk("recov.tap", tap_state, 1);
    chk("recov.ready", cmd_ready, 1);
    chk("recov.tms", TMS, 0);
    chk("recov.rspd", rsp_data, 0);
    chk("recov.busy", busy, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("recov.no_rspv[%0d]", k), rsp_valid, 0);
    end

    run_cmd("dr8r", 2'b10, 6'd8, 32'h0000_00A5, 13, 3, 8, 32'h0000_003C,
            64'(13'b1000000000110), 64'(13'b0001010010100),
            1'b1, 256'(56'h18544444444321), 32'h0000_003C);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
